max_pool_tx: RTL and testbench

- Producer side of the pooled-feature interface consumed by the final linear classifier.
- Takes per-frame conv outputs for 5 channels, arriving in parallel, and max-pools them with window POOL.
- Emits N_OUT pooled samples per channel with the staggered-valid convention: channel k is valid on out_val delayed by k cycles.
- Also drives o_0_val, the frame-active level the classifier uses as its cycle-counter enable and clear.

---
 rtl/max_pool_tx.sv | 246 ++++++++++++++++++++++++
 tb/tb_max_pool_tx.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/max_pool_tx.sv
// max_pool_tx: producer side of the pooled-feature interface.
// Max-pools five parallel conv channels over POOL samples and emits N_OUT
// pooled values per channel per frame, with max_k staggered k cycles behind
// out_val. o_0_val is the frame-active level the consumer uses as its
// cycle-counter enable; a restart drops it for exactly one cycle.
// Optional feature: define MAXPOOL_RELU_EN to clamp pooled values at zero.
module max_pool_tx #(
   parameter int unsigned DW    = 10,
   parameter int unsigned POOL  = 2,
   parameter int unsigned N_OUT = 27
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 frame_start,
   input  logic                 in_val,
   input  logic signed [DW-1:0] conv_0,
   input  logic signed [DW-1:0] conv_1,
   input  logic signed [DW-1:0] conv_2,
   input  logic signed [DW-1:0] conv_3,
   input  logic signed [DW-1:0] conv_4,
   output logic                 o_0_val,
   output logic                 out_val,
   output logic signed [DW-1:0] max_0,
   output logic signed [DW-1:0] max_1,
   output logic signed [DW-1:0] max_2,
   output logic signed [DW-1:0] max_3,
   output logic signed [DW-1:0] max_4,
   output logic                 frame_done,
   output logic [7:0]           drop_cnt
);

   localparam int unsigned NCH      = 5;
   localparam int unsigned WIN_W    = $clog2(POOL);
   localparam int unsigned OUT_W    = (N_OUT > 1) ? $clog2(N_OUT) : 1;
   localparam int unsigned DROP_W   = 8;
   localparam logic [DROP_W-1:0] DROP_MAX = '1;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_HOLD = 2'd2,
      S_GAP  = 2'd3
   } state_t;

   state_t               r_state;
   state_t               w_next;

   logic                 w_accept;
   logic                 w_close;
   logic                 w_restart;
   logic                 w_drop;
   logic                 w_win_end;
   logic                 w_last;

   logic [WIN_W-1:0]     r_win_cnt;
   logic [OUT_W-1:0]     r_out_cnt;
   logic [DROP_W-1:0]    r_drop_cnt;
   logic                 r_o_0_val;
   logic                 r_out_val;
   logic                 r_frame_done;
   logic [3:1]           r_vld;

   logic signed [DW-1:0] w_conv    [NCH];
   logic signed [DW-1:0] w_pool    [NCH];
   logic signed [DW-1:0] w_pool_q  [NCH];
   logic signed [DW-1:0] r_run_max [NCH];
   logic signed [DW-1:0] r_max_out [NCH];

   // Per-channel delay lines; channel k needs k stages ahead of max_k.
   logic signed [DW-1:0] r_dl_1;
   logic signed [DW-1:0] r_dl_2 [2];
   logic signed [DW-1:0] r_dl_3 [3];
   logic signed [DW-1:0] r_dl_4 [4];

   assign w_conv[0] = conv_0;
   assign w_conv[1] = conv_1;
   assign w_conv[2] = conv_2;
   assign w_conv[3] = conv_3;
   assign w_conv[4] = conv_4;

   assign w_win_end = (r_win_cnt == WIN_W'(POOL - 1));
   assign w_last    = (r_out_cnt == OUT_W'(N_OUT - 1));

   assign o_0_val    = r_o_0_val;
   assign out_val    = r_out_val;
   assign frame_done = r_frame_done;
   assign drop_cnt   = r_drop_cnt;
   assign max_0      = r_max_out[0];
   assign max_1      = r_max_out[1];
   assign max_2      = r_max_out[2];
   assign max_3      = r_max_out[3];
   assign max_4      = r_max_out[4];

   // FSM state register
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   // FSM next-state and per-cycle control strobes
   always_comb begin
      w_next    = r_state;
      w_accept  = 1'b0;
      w_close   = 1'b0;
      w_restart = 1'b0;
      w_drop    = 1'b0;
      unique case (r_state)
         S_IDLE: begin
            if (frame_start) begin
               w_next = S_RUN;
            end
         end
         S_RUN: begin
            if (frame_start) begin
               w_next    = S_GAP;
               w_restart = 1'b1;
            end else begin
               w_accept = in_val;
               w_close  = in_val & w_win_end;
               if (w_close && w_last) begin
                  w_next = S_HOLD;
               end
            end
         end
         S_HOLD: begin
            w_drop = in_val;
            if (frame_start) begin
               w_next    = S_GAP;
               w_restart = 1'b1;
            end
         end
         S_GAP: begin
            w_next = S_RUN;
         end
         default: begin
            w_next = S_IDLE;
         end
      endcase
   end

   // Running max including the current sample; first sample of a window loads
   always_comb begin
      for (int k = 0; k < NCH; k++) begin
         w_pool[k] = ((r_win_cnt == '0) || (w_conv[k] > r_run_max[k])) ?
                     w_conv[k] : r_run_max[k];
`ifdef MAXPOOL_RELU_EN
         w_pool_q[k] = w_pool[k][DW-1] ? '0 : w_pool[k];
`else
         w_pool_q[k] = w_pool[k];
`endif
      end
   end

   // Window position, running maxima and output count; a restart discards any partial window
   always_ff @(posedge clk) begin
      if (rst || w_restart) begin
         r_win_cnt <= '0;
         r_out_cnt <= '0;
         for (int k = 0; k < NCH; k++) begin
            r_run_max[k] <= '0;
         end
      end else if (w_accept) begin
         r_win_cnt <= w_close ? '0 : r_win_cnt + 1'b1;
         for (int k = 0; k < NCH; k++) begin
            r_run_max[k] <= w_pool[k];
         end
         if (w_close) begin
            r_out_cnt <= w_last ? '0 : r_out_cnt + 1'b1;
         end
      end
   end

   // Frame-active level and drop counter; a HOLD-state sample coincident with restart is charged to the new frame
   always_ff @(posedge clk) begin
      if (rst) begin
         r_o_0_val  <= 1'b0;
         r_drop_cnt <= '0;
      end else begin
         r_o_0_val <= (w_next == S_RUN) || (w_next == S_HOLD);
         if (w_restart) begin
            r_drop_cnt <= w_drop ? DROP_W'(1) : '0;
         end else if (w_drop && (r_drop_cnt != DROP_MAX)) begin
            r_drop_cnt <= r_drop_cnt + 1'b1;
         end
      end
   end

   // Output strobes, staggered delay lines and pooled output registers; in-flight results survive a restart
   always_ff @(posedge clk) begin
      if (rst) begin
         r_out_val    <= 1'b0;
         r_frame_done <= 1'b0;
         r_vld        <= '0;
         r_dl_1       <= '0;
         for (int k = 0; k < NCH; k++) begin
            r_max_out[k] <= '0;
         end
         for (int j = 0; j < 2; j++) begin
            r_dl_2[j] <= '0;
         end
         for (int j = 0; j < 3; j++) begin
            r_dl_3[j] <= '0;
         end
         for (int j = 0; j < 4; j++) begin
            r_dl_4[j] <= '0;
         end
      end else begin
         r_out_val    <= w_close;
         r_frame_done <= w_close & w_last;
         r_vld        <= {r_vld[2:1], r_out_val};

         if (w_close) begin
            r_max_out[0] <= w_pool_q[0];
            r_dl_1       <= w_pool_q[1];
            r_dl_2[0]    <= w_pool_q[2];
            r_dl_3[0]    <= w_pool_q[3];
            r_dl_4[0]    <= w_pool_q[4];
         end

         r_dl_2[1] <= r_dl_2[0];
         for (int j = 1; j < 3; j++) begin
            r_dl_3[j] <= r_dl_3[j-1];
         end
         for (int j = 1; j < 4; j++) begin
            r_dl_4[j] <= r_dl_4[j-1];
         end

         if (r_out_val) begin
            r_max_out[1] <= r_dl_1;
         end
         if (r_vld[1]) begin
            r_max_out[2] <= r_dl_2[1];
         end
         if (r_vld[2]) begin
            r_max_out[3] <= r_dl_3[2];
         end
         if (r_vld[3]) begin
            r_max_out[4] <= r_dl_4[3];
         end
      end
   end

endmodule

// File: tb/tb_max_pool_tx.sv
// tb_max_pool_tx: directed bench for max_pool_tx.
// Records every output per cycle, then compares against hand-computed values
// and a small behavioural model of the pooled stream.
module tb_max_pool_tx;

   localparam int DW    = 10;
   localparam int POOL  = 2;
   localparam int N_OUT = 27;
   localparam int NCH   = 5;
   localparam int HLEN  = 1024;

   logic                 clk = 1'b0;
   logic                 rst;
   logic                 frame_start;
   logic                 in_val;
   logic signed [DW-1:0] conv [NCH];
   logic                 o_0_val;
   logic                 out_val;
   logic                 frame_done;
   logic [7:0]           drop_cnt;
   logic signed [DW-1:0] mx [NCH];

   max_pool_tx #(.DW(DW), .POOL(POOL), .N_OUT(N_OUT)) u_dut (
      .clk         (clk),
      .rst         (rst),
      .frame_start (frame_start),
      .in_val      (in_val),
      .conv_0      (conv[0]),
      .conv_1      (conv[1]),
      .conv_2      (conv[2]),
      .conv_3      (conv[3]),
      .conv_4      (conv[4]),
      .o_0_val     (o_0_val),
      .out_val     (out_val),
      .max_0       (mx[0]),
      .max_1       (mx[1]),
      .max_2       (mx[2]),
      .max_3       (mx[3]),
      .max_4       (mx[4]),
      .frame_done  (frame_done),
      .drop_cnt    (drop_cnt)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Per-cycle output history, sampled mid-cycle
   int h_ov   [HLEN];
   int h_fd   [HLEN];
   int h_o0   [HLEN];
   int h_drop [HLEN];
   int h_max  [NCH][HLEN];

   always @(negedge clk) begin
      if (cyc < HLEN) begin
         h_ov[cyc]   = int'(out_val);
         h_fd[cyc]   = int'(frame_done);
         h_o0[cyc]   = int'(o_0_val);
         h_drop[cyc] = int'(drop_cnt);
         for (int k = 0; k < NCH; k++) h_max[k][cyc] = int'(mx[k]);
      end
   end

   int n_chk  = 0;
   int n_fail = 0;

   task automatic check(input string tag, input int obs, input int exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   function automatic int f(input int x);
`ifdef MAXPOOL_RELU_EN
      return (x < 0) ? 0 : x;
`else
      return x;
`endif
   endfunction

   // Behavioural model of the pooled stream
   bit m_run  = 1'b0;
   bit m_hold = 1'b0;
   int m_win  = 0;
   int m_out  = 0;
   int m_drop = 0;
   int m_max [NCH];
   int exp_cyc  [$];
   int exp_val  [$];
   int exp_done [$];

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      repeat (n) step();
   endtask

   task automatic send(input int v0, input int v1, input int v2, input int v3, input int v4);
      int v [NCH];
      int c;
      v = '{v0, v1, v2, v3, v4};
      c = cyc;
      in_val = 1'b1;
      for (int k = 0; k < NCH; k++) conv[k] = DW'(v[k]);
      step();
      in_val = 1'b0;
      if (m_run) begin
         for (int k = 0; k < NCH; k++)
            if (m_win == 0 || v[k] > m_max[k]) m_max[k] = v[k];
         m_win++;
         if (m_win == POOL) begin
            m_win = 0;
            exp_cyc.push_back(c + 1);
            for (int k = 0; k < NCH; k++) exp_val.push_back(f(m_max[k]));
            exp_done.push_back((m_out == N_OUT - 1) ? 1 : 0);
            m_out++;
            if (m_out == N_OUT) begin
               m_run  = 1'b0;
               m_hold = 1'b1;
            end
         end
      end else if (m_hold) begin
         m_drop = (m_drop < 255) ? m_drop + 1 : 255;
      end
   endtask

   task automatic start_frame(output int fs);
      fs = cyc;
      frame_start = 1'b1;
      step();
      frame_start = 1'b0;
      step();
      m_run  = 1'b1;
      m_hold = 1'b0;
      m_win  = 0;
      m_out  = 0;
      m_drop = 0;
   endtask

   task automatic clear_model();
      exp_cyc.delete();
      exp_val.delete();
      exp_done.delete();
   endtask

   // Compare observed out_val pulses in [from,to) with the model stream
   task automatic verify(input string tag, input int from, input int to);
      int pc [$];
      int nfd;
      int nexp;
      nfd  = 0;
      nexp = 0;
      for (int c = from; c < to; c++) begin
         if (h_ov[c] != 0) pc.push_back(c);
         nfd += h_fd[c];
      end
      check({tag, "_npulse"}, pc.size(), exp_cyc.size());
      for (int i = 0; i < pc.size() && i < exp_cyc.size(); i++) begin
         check($sformatf("%s_cyc_w%0d", tag, i), pc[i], exp_cyc[i]);
         check($sformatf("%s_fd_w%0d", tag, i), h_fd[pc[i]], exp_done[i]);
         for (int k = 0; k < NCH; k++)
            if (pc[i] + k < HLEN)
               check($sformatf("%s_max%0d_w%0d", tag, k, i), h_max[k][pc[i] + k], exp_val[i * NCH + k]);
      end
      foreach (exp_done[i]) nexp += exp_done[i];
      check({tag, "_fd_total"}, nfd, nexp);
      clear_model();
   endtask

   initial begin
      int fs;
      int fs2;
      int t;
      int ones;
      int zeros;

      rst = 1'b1;
      frame_start = 1'b0;
      in_val = 1'b0;
      for (int k = 0; k < NCH; k++) conv[k] = '0;
      idle(3);
      rst = 1'b0;
      step();

      // Reset state
      check("rst_o0", h_o0[3], 0);
      check("rst_ov", h_ov[3], 0);
      check("rst_fd", h_fd[3], 0);
      check("rst_drop", h_drop[3], 0);
      for (int k = 0; k < NCH; k++) check($sformatf("rst_max%0d", k), h_max[k][3], 0);

      // Basic frame: conv_0=i, others -i, 54 consecutive samples
      start_frame(fs);
      for (int i = 0; i < 54; i++) send(i, -i, -i, -i, -i);
      idle(8);
      check("basic_o0_idle", h_o0[fs], 0);
      check("basic_o0_rise", h_o0[fs + 1], 1);
      check("basic_no_early_ov", h_ov[fs + 3], 0);
      check("basic_first_ov", h_ov[fs + 4], 1);
      check("basic_first_max0", h_max[0][fs + 4], 1);
      check("basic_first_max1", h_max[1][fs + 5], f(0));
      check("basic_last_max0", h_max[0][fs + 56], 53);
      check("basic_last_fd", h_fd[fs + 56], 1);
      check("basic_last_max4", h_max[4][fs + 60], f(-52));
      ones = 0;
      for (int c = fs + 1; c < cyc; c++) ones += h_o0[c];
      check("basic_o0_high", ones, cyc - fs - 1);
      verify("basic", fs, cyc);

      // Gapped input with signed-compare corner pairs, from HOLD
      start_frame(fs);
      send(-512,   -1,  100,  0, -7); idle(2);
      send(  -1, -512,   99,  0, -8); idle(2);
      send( 511, -512, -100,  5,  3); idle(2);
      send(-512,  511,  -99, -5,  3); idle(2);
      send(  -5,   -3,    1,  2, -2); idle(2);
      send(  -3,   -5,    2,  1, -1); idle(2);
      idle(6);
      check("gap_o0_low", h_o0[fs + 1], 0);
      check("gap_o0_back", h_o0[fs + 2], 1);
      check("gap_ov1", h_ov[fs + 6], 1);
      check("gap_neg_pair", h_max[0][fs + 6], f(-1));
      check("gap_max0_hold", h_max[0][fs + 10], f(-1));
      check("gap_pos_pair", h_max[0][fs + 12], 511);
      check("gap_pos_pair_ch1", h_max[1][fs + 13], 511);
      check("gap_relu_pair", h_max[0][fs + 18], f(-3));
      check("gap_max4_w2", h_max[4][fs + 22], f(-1));
      verify("gapped", fs, cyc);

      // Mid-frame restart after 13 samples
      start_frame(fs);
      for (int i = 0; i < 13; i++) send(i * 7 - 40, 40 - i * 7, i, -i, i * 3);
      start_frame(fs2);
      for (int i = 0; i < 54; i++)
         send((i * 37) % 1000 - 500, 499 - (i * 37) % 1000, i * 5 - 100, 200 - i * 3, (i % 7) * 70 - 210);
      idle(8);
      zeros = 0;
      for (int c = fs2 + 1; c < cyc; c++) zeros += (h_o0[c] == 0) ? 1 : 0;
      check("restart_o0_low_cycles", zeros, 1);
      check("restart_o0_low_at", h_o0[fs2 + 1], 0);
      check("restart_partial_dropped", h_ov[fs2 + 3], 0);
      check("restart_first_ov", h_ov[fs2 + 4], 1);
      check("restart_first_max0", h_max[0][fs2 + 4], f(-463));
      verify("restart", fs, cyc);

      // Overflow: 60 samples in one frame
      start_frame(fs);
      for (int i = 0; i < 60; i++) send(i % 9 - 4, 4 - i % 9, i % 5, -(i % 3), i);
      idle(6);
      check("ovf_drop_cnt", h_drop[cyc - 1], 6);
      check("ovf_drop_model", h_drop[cyc - 1], m_drop);
      verify("overflow", fs, cyc);

      // Reset while the staggered pipeline is in flight
      start_frame(fs);
      send(10, 1, 2, 3, 4);
      send(20, 5, 6, 7, 8);
      send(30, 9, 9, 9, 9);
      t = cyc;
      send(40, 11, 12, 13, 14);
      rst = 1'b1;
      in_val = 1'b1;
      step();
      rst = 1'b0;
      in_val = 1'b0;
      m_run  = 1'b0;
      m_hold = 1'b0;
      clear_model();
      for (int i = 0; i < 10; i++) send(100 + i, 100, 100, 100, 100);
      idle(2);
      check("rstmid_ov_before", h_ov[t + 1], 1);
      check("rstmid_max0_before", h_max[0][t + 1], 40);
      for (int c = t + 2; c < t + 12; c++) begin
         check($sformatf("rstmid_ov_c%0d", c - t), h_ov[c], 0);
         check($sformatf("rstmid_o0_c%0d", c - t), h_o0[c], 0);
         check($sformatf("rstmid_fd_c%0d", c - t), h_fd[c], 0);
         check($sformatf("rstmid_drop_c%0d", c - t), h_drop[c], 0);
         for (int k = 0; k < NCH; k++)
            check($sformatf("rstmid_max%0d_c%0d", k, c - t), h_max[k][c], 0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
